// File: rtl/req_arbiter_rr.sv
// Three-requester round-robin arbiter with a bounded hold time.
// Every output, including the FSM state, is a register; a timed-out owner keeps lowest priority.
module req_arbiter_rr #(
    parameter int MAX_HOLD = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [2:0] req,
    input  logic       done,
    output logic [2:0] grant,
    output logic [1:0] grant_idx,
    output logic       grant_valid,
    output logic       timeout,
    output logic       fsm_state
);

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    state_t     state;
    logic [1:0] last_idx;
    logic [7:0] hold_cnt;
    logic [1:0] cand_1;
    logic [1:0] cand_2;
    logic [1:0] winner;
    logic       release_now;

    function automatic logic [1:0] next_idx(input logic [1:0] i);
        return (i == 2'd2) ? 2'd0 : i + 2'd1;
    endfunction

    // Search last+1, then last+2; if neither requests, last_idx itself is the only candidate left.
    always_comb begin
        cand_1 = next_idx(last_idx);
        cand_2 = next_idx(cand_1);
        winner = last_idx;
        if (req[cand_1]) begin
            winner = cand_1;
        end else if (req[cand_2]) begin
            winner = cand_2;
        end
    end

    assign release_now = done || !req[grant_idx];
    assign fsm_state   = state;

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            grant       <= 3'b000;
            grant_idx   <= 2'd0;
            grant_valid <= 1'b0;
            timeout     <= 1'b0;
            hold_cnt    <= 8'd0;
            last_idx    <= 2'd2;
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (req != 3'b000) begin
                        state       <= OWN;
                        grant       <= 3'b001 << winner;
                        grant_idx   <= winner;
                        grant_valid <= 1'b1;
                        last_idx    <= winner;
                        hold_cnt    <= 8'd1;
                    end
                end
                OWN: begin
                    if (release_now || (hold_cnt == 8'(MAX_HOLD))) begin
                        // A release on the limit cycle is an ordinary release, not a timeout.
                        state       <= IDLE;
                        grant       <= 3'b000;
                        grant_idx   <= 2'd0;
                        grant_valid <= 1'b0;
                        hold_cnt    <= 8'd0;
                        timeout     <= !release_now;
                    end else begin
                        hold_cnt <= hold_cnt + 8'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/req_arbiter_rr.md
REQ_ARBITER_RR -- requirements
Module: req_arbiter_rr

Interface
REQ-001 Parameter MAX_HOLD, default 16, maximum number of consecutive cycles one requester may hold the grant; legal range 2..255.
REQ-002 Port clock  input  1  single rising-edge clock for all state.
REQ-003 Port reset  input  1  synchronous, active-high reset, sampled on rising edge of clock.
REQ-004 Port req  input  3  request lines; req[i]=1 means requester i wants the shared resource; level-sensitive, held until served.
REQ-005 Port done  input  1  release from the current owner; meaningful only while grant_valid=1, ignored otherwise.
REQ-006 Port grant  output  3  one-hot grant vector, all-zero when no owner.
REQ-007 Port grant_idx  output  2  binary index of current owner (0..2); 0 when grant_valid=0.
REQ-008 Port grant_valid  output  1  1 while some requester owns the resource.
REQ-009 Port timeout  output  1  one-cycle pulse when a grant is forcibly revoked at MAX_HOLD.
REQ-010 All outputs SHALL be driven directly from registers, with no combinational path from inputs to outputs.

Function
REQ-011 The block SHALL implement a two-state FSM: IDLE (no owner) and OWN (grant_valid=1).
REQ-012 State SHALL include a 2-bit last_idx register holding the most recently granted index.
REQ-013 In IDLE with req!=0, the block SHALL select the winner by round-robin: search order last_idx+1, last_idx+2, last_idx+3, modulo 3 (wrap 2->0).
REQ-014 The selected requester SHALL see its grant on the cycle after req is sampled (latency 1 cycle); in that same edge, grant_idx=winner, grant_valid=1, last_idx=winner, hold_cnt=1, and the FSM enters OWN.
REQ-015 In IDLE with req=0, all outputs SHALL remain 0 and last_idx SHALL be unchanged.
REQ-016 In OWN, grant, grant_idx and grant_valid SHALL stay constant; changes on other req bits SHALL have no effect.
REQ-017 In OWN, a release SHALL occur when done=1 or req[grant_idx]=0; on that edge the FSM SHALL return to IDLE, grant=0, grant_valid=0, grant_idx=0.
REQ-018 In OWN, when hold_cnt==MAX_HOLD and no release condition holds, the FSM SHALL return to IDLE, clear the grant outputs, and assert timeout=1 for exactly that one following cycle.
REQ-019 Otherwise in OWN, hold_cnt SHALL increment by 1 each cycle; hold_cnt is 8 bits and never exceeds MAX_HOLD.
REQ-020 When release and MAX_HOLD coincide on the same cycle, the block SHALL treat it as a normal release with timeout=0.
REQ-021 At least one cycle with grant_valid=0 SHALL separate any two grants, including back-to-back grants to different requesters.
REQ-022 A requester revoked by timeout SHALL be re-eligible in IDLE, with round-robin priority applied after the other requesters.
REQ-023 grant SHALL always equal (grant_valid ? 1<<grant_idx : 0); the bench checks this invariant every cycle.

Reset
REQ-024 While reset=1 at a clock edge, the FSM SHALL enter IDLE, and grant, grant_idx, grant_valid, timeout and hold_cnt SHALL all become 0.
REQ-025 Reset SHALL set last_idx=2, so that after reset requester 0 has the highest priority.
REQ-026 Reset asserted during OWN SHALL drop the grant on that edge, without a timeout pulse.
REQ-027 Reset SHALL take priority over all other inputs on the same edge.

Verification
REQ-028 After reset, drive req=3'b111 at cycle 0 -> cycle 1 shows grant=001, grant_idx=0, grant_valid=1.
REQ-029 Keep req=111 and pulse done one cycle per grant -> owners follow the order 0,1,2,0 with one idle cycle between grants.
REQ-030 With MAX_HOLD=4, hold req=3'b010 and done=0 -> grant=010 for exactly 4 cycles, then grant=0 with timeout=1 for one cycle, then a re-grant to 1 one cycle later.
REQ-031 Owner 1 active and req changes from 010 to 110 mid-grant -> grant stays 010 until done; the next grant goes to 2.
REQ-032 Owner 0 active and req[0] drops to 0 with done=0 -> grant clears next cycle and timeout=0.
REQ-033 Reset asserted during OWN with req=111 -> all outputs 0 on the next edge; the first grant after reset release goes to requester 0.
